// File: rtl/iteration_scheduler.sv
// Iteration scheduler: runs the update engines in fixed intervals, snapshots the
// global accumulator after each interval and stops on convergence, cap or timeout.
module iteration_scheduler #(
    parameter int ACCUM_WIDTH    = 32,
    parameter int ITER_WIDTH     = 16,
    parameter int CHECK_INTERVAL = 1000,
    parameter int MAX_ITER       = 100,
    parameter int ACK_TIMEOUT    = 4096
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [ACCUM_WIDTH-1:0] threshold_i,
    input  logic [ACCUM_WIDTH-1:0] accum_value_i,
    input  logic                   accum_valid_i,
    input  logic                   flush_done_i,
    output logic                   start_update_o,
    output logic                   check_terminate_o,
    output logic                   flush_ddr_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   timeout_err_o,
    output logic [ITER_WIDTH-1:0]  iteration_count_o,
    output logic [ACCUM_WIDTH-1:0] last_accum_o
);

    localparam int IV_W = $clog2(CHECK_INTERVAL);
    localparam int TO_W = $clog2(ACK_TIMEOUT);
    localparam logic [IV_W-1:0]       IV_LAST  = IV_W'(CHECK_INTERVAL - 1);
    localparam logic [TO_W-1:0]       TO_LAST  = TO_W'(ACK_TIMEOUT - 2);
    localparam logic [ITER_WIDTH-1:0] ITER_CAP = ITER_WIDTH'(MAX_ITER);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_CHECK,
        S_WAIT_ACCUM,
        S_FLUSH,
        S_WAIT_FLUSH,
        S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [IV_W-1:0]        intervalCnt_q, intervalCnt_d;
    logic [TO_W-1:0]        timeoutCnt_q, timeoutCnt_d;
    logic                   firstSample_q, firstSample_d;
    logic [ACCUM_WIDTH-1:0] threshold_q, threshold_d;
    logic [ITER_WIDTH-1:0]  iterCount_q, iterCount_d;
    logic [ACCUM_WIDTH-1:0] lastAccum_q, lastAccum_d;
    logic                   timeoutErr_q, timeoutErr_d;

    logic                   startUpdate_q, checkTerminate_q, flushDdr_q, busy_q, done_q;

    logic [ACCUM_WIDTH:0]   delta;
    logic                   converged;
    logic [ITER_WIDTH-1:0]  iterInc;

    always_comb begin
        delta = '0;
        if (accum_value_i >= lastAccum_q) begin
            delta = {1'b0, accum_value_i} - {1'b0, lastAccum_q};
        end else begin
            delta = {1'b0, lastAccum_q} - {1'b0, accum_value_i};
        end
        converged = !firstSample_q && (delta < {1'b0, threshold_q});
        iterInc   = (iterCount_q == '1) ? iterCount_q : iterCount_q + ITER_WIDTH'(1);
    end

    always_comb begin
        state_d       = state_q;
        intervalCnt_d = intervalCnt_q;
        timeoutCnt_d  = timeoutCnt_q;
        firstSample_d = firstSample_q;
        threshold_d   = threshold_q;
        iterCount_d   = iterCount_q;
        lastAccum_d   = lastAccum_q;
        timeoutErr_d  = timeoutErr_q;

        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_d       = S_RUN;
                        intervalCnt_d = '0;
                        iterCount_d   = '0;
                        lastAccum_d   = '0;
                        timeoutErr_d  = 1'b0;
                        firstSample_d = 1'b1;
                        threshold_d   = threshold_i;
                    end
                end
                S_RUN: begin
                    if (intervalCnt_q == IV_LAST) begin
                        intervalCnt_d = '0;
                        state_d       = S_CHECK;
                    end else begin
                        intervalCnt_d = intervalCnt_q + IV_W'(1);
                    end
                end
                S_CHECK: begin
                    timeoutCnt_d = '0;
                    state_d      = S_WAIT_ACCUM;
                end
                S_WAIT_ACCUM: begin
                    timeoutCnt_d = timeoutCnt_q + TO_W'(1);
                    // A sample arriving on the timeout cycle is still accepted.
                    if (accum_valid_i) begin
                        lastAccum_d   = accum_value_i;
                        iterCount_d   = iterInc;
                        firstSample_d = 1'b0;
                        state_d       = (converged || iterInc == ITER_CAP) ? S_FLUSH : S_RUN;
                    end else if (timeoutCnt_q == TO_LAST) begin
                        timeoutErr_d = 1'b1;
                        state_d      = S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    state_d = S_WAIT_FLUSH;
                end
                S_WAIT_FLUSH: begin
                    if (flush_done_i) begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q          <= S_IDLE;
            intervalCnt_q    <= '0;
            timeoutCnt_q     <= '0;
            firstSample_q    <= 1'b1;
            threshold_q      <= '0;
            iterCount_q      <= '0;
            lastAccum_q      <= '0;
            timeoutErr_q     <= 1'b0;
            startUpdate_q    <= 1'b0;
            checkTerminate_q <= 1'b0;
            flushDdr_q       <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            intervalCnt_q    <= intervalCnt_d;
            timeoutCnt_q     <= timeoutCnt_d;
            firstSample_q    <= firstSample_d;
            threshold_q      <= threshold_d;
            iterCount_q      <= iterCount_d;
            lastAccum_q      <= lastAccum_d;
            timeoutErr_q     <= timeoutErr_d;
            startUpdate_q    <= (state_d == S_RUN);
            checkTerminate_q <= (state_d == S_CHECK);
            flushDdr_q       <= (state_d == S_FLUSH);
            busy_q           <= (state_d != S_IDLE) && (state_d != S_DONE);
            done_q           <= (state_d == S_DONE);
        end
    end

    assign start_update_o    = startUpdate_q;
    assign check_terminate_o = checkTerminate_q;
    assign flush_ddr_o       = flushDdr_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign timeout_err_o     = timeoutErr_q;
    assign iteration_count_o = iterCount_q;
    assign last_accum_o      = lastAccum_q;

endmodule

// File: tb/tb_iteration_scheduler.sv
// Bench for iteration_scheduler: a small convergence model feeds a scoreboard queue
// with the expected count/accumulator/flush result of every accumulator sample.
module tb_iteration_scheduler;

    localparam int AW = 32;
    localparam int IW = 16;
    localparam int CI = 8;
    localparam int MI = 4;
    localparam int AT = 16;

    logic          clk = 1'b0;
    logic          reset, start, abort, accumValid, flushDone;
    logic [AW-1:0] threshold, accumValue;
    logic          start_update_o, check_terminate_o, flush_ddr_o, busy_o, done_o, timeout_err_o;
    logic [IW-1:0] iteration_count_o;
    logic [AW-1:0] last_accum_o;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        int unsigned cnt;
        logic [AW-1:0] accum;
        bit flush;
    } exp_t;
    exp_t sbQ[$];

    int unsigned   mCnt;
    logic [AW-1:0] mPrev, mThr;
    bit            mFirst;

    iteration_scheduler #(
        .ACCUM_WIDTH(AW), .ITER_WIDTH(IW), .CHECK_INTERVAL(CI),
        .MAX_ITER(MI), .ACK_TIMEOUT(AT)
    ) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
        .threshold_i(threshold), .accum_value_i(accumValue), .accum_valid_i(accumValid),
        .flush_done_i(flushDone), .start_update_o(start_update_o),
        .check_terminate_o(check_terminate_o), .flush_ddr_o(flush_ddr_o), .busy_o(busy_o),
        .done_o(done_o), .timeout_err_o(timeout_err_o),
        .iteration_count_o(iteration_count_o), .last_accum_o(last_accum_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic startRun(input logic [AW-1:0] thr);
        threshold = thr;
        start     = 1'b1;
        tick();
        start  = 1'b0;
        mCnt   = 0;
        mPrev  = '0;
        mThr   = thr;
        mFirst = 1'b1;
        checkOutput("startUpdate", start_update_o, 1);
        checkOutput("startTmoClr", timeout_err_o, 0);
        checkOutput("startIterClr", iteration_count_o, 0);
    endtask

    task automatic waitCheck(input string tag);
        int runHigh = 0;
        int n = 0;
        while (!check_terminate_o && n < 50) begin
            if (start_update_o) runHigh++;
            tick();
            n++;
        end
        checkOutput({tag, "_runLen"}, runHigh, CI);
        checkOutput({tag, "_chkPulse"}, check_terminate_o, 1);
        checkOutput({tag, "_updOff"}, start_update_o, 0);
    endtask

    task automatic applyStimulus(input logic [AW-1:0] value);
        logic [AW:0] d;
        exp_t e;
        exp_t got;
        d = (value >= mPrev) ? ({1'b0, value} - {1'b0, mPrev}) : ({1'b0, mPrev} - {1'b0, value});
        mCnt++;
        e.flush = (!mFirst && (d < {1'b0, mThr})) || (mCnt == MI);
        mFirst  = 1'b0;
        mPrev   = value;
        e.cnt   = mCnt;
        e.accum = value;
        sbQ.push_back(e);
        accumValid = 1'b1;
        accumValue = value;
        tick();
        accumValid = 1'b0;
        got = sbQ.pop_front();
        checkOutput("sbIterCount", iteration_count_o, got.cnt);
        checkOutput("sbLastAccum", last_accum_o, got.accum);
        checkOutput("sbFlush", flush_ddr_o, got.flush);
        if (!got.flush) checkOutput("sbBackToRun", start_update_o, 1);
    endtask

    task automatic finishFlush();
        tick();
        checkOutput("flushOnePulse", flush_ddr_o, 0);
        checkOutput("waitFlushBusy", busy_o, 1);
        flushDone = 1'b1;
        tick();
        flushDone = 1'b0;
        checkOutput("doneHigh", done_o, 1);
        checkOutput("doneNotBusy", busy_o, 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_upd"}, start_update_o, 0);
        checkOutput({tag, "_chk"}, check_terminate_o, 0);
        checkOutput({tag, "_flush"}, flush_ddr_o, 0);
        checkOutput({tag, "_busy"}, busy_o, 0);
        checkOutput({tag, "_done"}, done_o, 0);
        checkOutput({tag, "_tmo"}, timeout_err_o, 0);
        checkOutput({tag, "_iter"}, iteration_count_o, 0);
        checkOutput({tag, "_accum"}, last_accum_o, 0);
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; abort = 1'b0; accumValid = 1'b0; flushDone = 1'b0;
        threshold = '0; accumValue = '0;
        repeat (3) tick();
        checkAllZero("reset");
        reset = 1'b0;
        tick();

        // Basic convergence loop
        startRun(5);
        waitCheck("basic1"); repeat (3) tick(); applyStimulus(100);
        waitCheck("basic2"); repeat (3) tick(); applyStimulus(50);
        waitCheck("basic3"); repeat (3) tick(); applyStimulus(52);
        finishFlush();
        checkOutput("basicIter", iteration_count_o, 3);
        checkOutput("basicAccum", last_accum_o, 52);

        // First-sample guard, then abort during RUN
        startRun(5);
        waitCheck("guard"); repeat (2) tick(); applyStimulus(0);
        repeat (2) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        checkOutput("abortRunUpd", start_update_o, 0);
        checkOutput("abortRunBusy", busy_o, 0);
        checkOutput("abortRunIter", iteration_count_o, 1);

        // Iteration cap
        startRun(5);
        for (int i = 0; i < MI; i++) begin
            waitCheck("cap");
            tick();
            applyStimulus((i % 2) ? 1000 : 0);
        end
        finishFlush();
        checkOutput("capIter", iteration_count_o, MI);
        checkOutput("capTmo", timeout_err_o, 0);

        // Accumulator timeout
        startRun(5);
        waitCheck("tmo");
        n = 0;
        while (!flush_ddr_o && n < 40) begin
            tick();
            n++;
        end
        checkOutput("tmoLatency", n, AT);
        checkOutput("tmoErr", timeout_err_o, 1);
        finishFlush();
        checkOutput("tmoErrSticky", timeout_err_o, 1);
        startRun(5);

        // Abort during WAIT_ACCUM, then start+abort together
        waitCheck("abw1"); tick(); applyStimulus(10);
        waitCheck("abw2"); repeat (2) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        checkOutput("abortWaitUpd", start_update_o, 0);
        checkOutput("abortWaitChk", check_terminate_o, 0);
        checkOutput("abortWaitBusy", busy_o, 0);
        checkOutput("abortWaitIter", iteration_count_o, 1);
        checkOutput("abortWaitAccum", last_accum_o, 10);
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        checkOutput("startAbortUpd", start_update_o, 0);
        checkOutput("startAbortBusy", busy_o, 0);
        accumValid = 1'b1; accumValue = 999; tick(); accumValid = 1'b0;
        checkOutput("strayValidAccum", last_accum_o, 10);
        checkOutput("strayValidIter", iteration_count_o, 1);

        // Reset during WAIT_FLUSH, then late flush_done in IDLE
        startRun(5);
        waitCheck("rst1"); tick(); applyStimulus(7);
        waitCheck("rst2"); tick(); applyStimulus(8);
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        checkAllZero("rstFlush");
        flushDone = 1'b1; tick(); flushDone = 1'b0;
        tick();
        checkOutput("lateFlushDone", done_o, 0);
        checkOutput("lateFlushBusy", busy_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/iteration_scheduler.md
Name: iteration_scheduler

Overview:
- Sequences the compute system's iterative update loop.
- Asserts start_update to run the accumulate/update engines, then periodically pauses them and pulses check_terminate.
- Samples the returned global accumulator value and compares it with the previous sample to decide convergence.
- On convergence, iteration cap or timeout, issues a single DDR flush and reports completion to the host-side control logic.

Parameters:
- ACCUM_WIDTH, 32, width of accumulator value and threshold.
- ITER_WIDTH, 16, width of iteration counter.
- CHECK_INTERVAL, 1000, cycles of RUN between termination checks (>=2).
- MAX_ITER, 100, maximum number of checks before forced termination (>=1).
- ACK_TIMEOUT, 4096, cycles to wait for accum_valid before timeout.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, one-cycle go pulse from host; honoured only in IDLE or DONE.
- abort, in, 1, synchronous abort; forces IDLE from any state.
- threshold, in, ACCUM_WIDTH, convergence threshold; sampled on accepted start.
- accum_value, in, ACCUM_WIDTH, global accumulator sum from compute system.
- accum_valid, in, 1, qualifies accum_value; one-cycle pulse.
- flush_done, in, 1, one-cycle pulse from DDR read/flush logic.
- start_update, out, 1, level enable to update engines.
- check_terminate, out, 1, one-cycle pulse requesting an accumulator snapshot.
- flush_ddr, out, 1, one-cycle pulse requesting a DDR flush.
- busy, out, 1, high in every state except IDLE and DONE.
- done, out, 1, high in DONE.
- timeout_err, out, 1, sticky until next accepted start or reset.
- iteration_count, out, ITER_WIDTH, number of completed checks.
- last_accum, out, ACCUM_WIDTH, most recently sampled accum_value.

Behaviour:
- Reset:
  - All outputs 0; state IDLE.
  - Internal interval/timeout counters 0; first_sample flag 1; threshold register 0.
- Accepted start (IDLE or DONE):
  - Next cycle: state RUN, start_update=1.
  - Clears iteration_count, last_accum, timeout_err and the interval counter; sets first_sample=1; latches threshold.
  - start in any other state is ignored.
- RUN:
  - Interval counter increments each cycle.
  - When it equals CHECK_INTERVAL-1 -> CHECK; counter cleared.
  - start_update stays high for exactly CHECK_INTERVAL cycles.
- CHECK (1 cycle):
  - start_update=0, check_terminate=1.
  - Next state WAIT_ACCUM, timeout counter cleared.
- WAIT_ACCUM:
  - start_update=0.
  - Timeout counter increments each cycle.
  - On accum_valid:
    - Latch last_accum=accum_value.
    - iteration_count increments by 1, saturating at all-ones.
    - delta = |accum_value - last_accum(old)|, computed unsigned in ACCUM_WIDTH+1 bits.
    - converged = (first_sample==0) and (delta < threshold).
    - Clear first_sample.
    - If converged, or the new iteration_count == MAX_ITER -> FLUSH; else -> RUN.
  - If the timeout counter reaches ACK_TIMEOUT-1 without accum_valid: set timeout_err -> FLUSH.
  - accum_valid in the same cycle as the timeout: accum_valid wins, no error.
- FLUSH (1 cycle): flush_ddr=1 -> WAIT_FLUSH.
- WAIT_FLUSH:
  - On flush_done -> DONE.
  - No timeout; abort is the only escape.
- DONE: done=1, busy=0; outputs last_accum/iteration_count held until next accepted start.
- abort:
  - Highest priority after reset; next state IDLE.
  - start_update, check_terminate, flush_ddr and done all 0 next cycle.
  - iteration_count, last_accum and timeout_err are held (for host readback).
  - abort and start in the same cycle: abort wins.
- Stray pulses:
  - accum_valid outside WAIT_ACCUM is ignored.
  - flush_done outside WAIT_FLUSH is ignored.
- Pulse outputs (check_terminate, flush_ddr) are never high for more than one consecutive cycle.
- All outputs are registered; no combinational input-to-output paths.

Test Plan:
- Basic loop, CHECK_INTERVAL=8, threshold=5:
  - Stimulus: start; accum_valid 3 cycles after each check_terminate with values 100, 50, 52.
  - Required:
    - start_update high for 8 cycles per interval.
    - Three check_terminate pulses.
    - After the third sample, delta 2<5 gives flush_ddr one cycle later.
    - flush_done gives done=1, iteration_count=3, last_accum=52.
- First-sample guard:
  - Stimulus: first accum_value=0 with threshold=5.
  - Required: no termination; return to RUN; iteration_count=1.
- Iteration cap, MAX_ITER=4:
  - Stimulus: values alternate 0 and 1000.
  - Required: flush_ddr after the 4th sample; done with iteration_count=4; timeout_err=0.
- Timeout, ACK_TIMEOUT=16:
  - Stimulus: never pulse accum_valid.
  - Required: flush_ddr exactly 16 cycles after check_terminate; timeout_err=1; done after flush_done.
  - Follow-up: a new start clears timeout_err.
- Abort mid-WAIT_ACCUM and mid-RUN:
  - Required: IDLE next cycle; start_update=0; busy=0; iteration_count retained.
  - Follow-up: a simultaneous start+abort leaves the block in IDLE.
- Reset mid-WAIT_FLUSH:
  - Required: all outputs 0 next cycle.
  - Follow-up: a late flush_done in IDLE produces no state change.
